// File: rtl/bcrypt_tx_arbiter.sv
// Shares the 10-bit bcrypt bus from the batch source across N cores: one-time
// P/S init per core, round-robin data dispatch, end-of-generation drain, watchdog.
module bcrypt_tx_arbiter #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned TIMEOUT = 8192
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   init_ready,
    input  logic                   data_ready,
    input  logic                   bcdata_gen_end,
    output logic                   start_init_tx,
    output logic                   start_data_tx,
    input  logic                   init_tx_done,
    input  logic                   data_tx_done,
    input  logic [7:0]             din,
    input  logic [1:0]             ctrl_in,
    output logic [7:0]             core_dout,
    output logic [2*N_CORES-1:0]   core_ctrl,
    input  logic [N_CORES-1:0]     core_idle,
    output logic                   gen_end_out,
    output logic [1:0]             error
);
    localparam int unsigned SW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_TX,
        ST_DATA_TX,
        ST_GEN_END_WAIT,
        ST_GEN_END_TX,
        ST_ERROR
    } state_t;

    state_t               state, state_nx;
    logic [SW-1:0]        sel, sel_nx;
    logic [SW-1:0]        rr, rr_nx;
    logic [N_CORES-1:0]   inited, inited_nx;
    logic [N_CORES-1:0]   pending, pending_nx;
    logic [WW-1:0]        wdog, wdog_nx;
    logic                 start_init_nx, start_data_nx, gen_end_nx;
    logic [1:0]           error_nx;
    logic [2*N_CORES-1:0] core_ctrl_nx;

    logic [N_CORES-1:0]   eligible;
    logic                 init_found, data_found;
    logic [SW-1:0]        init_idx, data_idx;
    logic                 wdog_expired;

    assign eligible     = core_idle & ~pending & inited;
    assign wdog_expired = (wdog == WW'(TIMEOUT - 1));

    // Candidate search: lowest uninitialised idle core, and round-robin eligible core from rr.
    always_comb begin
        int unsigned   idx;
        logic [SW-1:0] cand;
        idx        = 0;
        cand       = '0;
        init_found = 1'b0;
        init_idx   = '0;
        data_found = 1'b0;
        data_idx   = '0;
        for (int i = 0; i < int'(N_CORES); i++) begin
            if (!init_found && core_idle[i] && !inited[i]) begin
                init_found = 1'b1;
                init_idx   = SW'(i);
            end
        end
        for (int k = 0; k < int'(N_CORES); k++) begin
            idx  = (32'(rr) + 32'(k)) % N_CORES;
            cand = SW'(idx);
            if (!data_found && eligible[cand]) begin
                data_found = 1'b1;
                data_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nx      = state;
        sel_nx        = sel;
        rr_nx         = rr;
        inited_nx     = inited;
        pending_nx    = pending & core_idle;
        wdog_nx       = wdog;
        start_init_nx = 1'b0;
        start_data_nx = 1'b0;
        gen_end_nx    = 1'b0;
        error_nx      = error;
        core_ctrl_nx  = '0;

        case (state)
            ST_IDLE: begin
                if (init_tx_done || data_tx_done) begin
                    error_nx[1] = 1'b1;
                    state_nx    = ST_ERROR;
                end else if (init_ready && init_found) begin
                    sel_nx        = init_idx;
                    start_init_nx = 1'b1;
                    wdog_nx       = '0;
                    state_nx      = ST_INIT_TX;
                end else if (data_ready && !bcdata_gen_end && data_found) begin
                    sel_nx               = data_idx;
                    pending_nx[data_idx] = 1'b1;
                    start_data_nx        = 1'b1;
                    rr_nx                = (32'(data_idx) == N_CORES - 1) ? '0 : data_idx + SW'(1);
                    wdog_nx              = '0;
                    state_nx             = ST_DATA_TX;
                end else if (data_ready && bcdata_gen_end) begin
                    state_nx = ST_GEN_END_WAIT;
                end
            end
            ST_INIT_TX: begin
                if (data_tx_done) begin
                    error_nx[1] = 1'b1;
                    state_nx    = ST_ERROR;
                end else if (init_tx_done) begin
                    inited_nx[sel] = 1'b1;
                    state_nx       = ST_IDLE;
                end else if (wdog_expired) begin
                    error_nx[0] = 1'b1;
                    state_nx    = ST_ERROR;
                end else begin
                    wdog_nx = wdog + WW'(1);
                end
            end
            ST_DATA_TX: begin
                if (init_tx_done) begin
                    error_nx[1] = 1'b1;
                    state_nx    = ST_ERROR;
                end else if (data_tx_done) begin
                    state_nx = ST_IDLE;
                end else if (wdog_expired) begin
                    error_nx[0] = 1'b1;
                    state_nx    = ST_ERROR;
                end else begin
                    wdog_nx = wdog + WW'(1);
                end
            end
            ST_GEN_END_WAIT: begin
                if (init_tx_done || data_tx_done) begin
                    error_nx[1] = 1'b1;
                    state_nx    = ST_ERROR;
                end else if (core_idle == '1 && pending == '0) begin
                    start_data_nx = 1'b1;
                    wdog_nx       = '0;
                    state_nx      = ST_GEN_END_TX;
                end
            end
            ST_GEN_END_TX: begin
                if (init_tx_done) begin
                    error_nx[1] = 1'b1;
                    state_nx    = ST_ERROR;
                end else if (data_tx_done) begin
                    gen_end_nx = 1'b1;
                    state_nx   = ST_IDLE;
                end else if (wdog_expired) begin
                    error_nx[0] = 1'b1;
                    state_nx    = ST_ERROR;
                end else begin
                    wdog_nx = wdog + WW'(1);
                end
            end
            ST_ERROR: begin
                state_nx = ST_ERROR;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Only the selected core sees ctrl; the gen-end transfer carries no payload.
        if ((state == ST_INIT_TX || state == ST_DATA_TX) && state_nx != ST_ERROR) begin
            for (int i = 0; i < int'(N_CORES); i++) begin
                if (sel == SW'(i)) begin
                    core_ctrl_nx[2*i +: 2] = ctrl_in;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            sel           <= '0;
            rr            <= '0;
            inited        <= '0;
            pending       <= '0;
            wdog          <= '0;
            start_init_tx <= 1'b0;
            start_data_tx <= 1'b0;
            gen_end_out   <= 1'b0;
            error         <= 2'b00;
            core_dout     <= 8'h00;
            core_ctrl     <= '0;
        end else begin
            state         <= state_nx;
            sel           <= sel_nx;
            rr            <= rr_nx;
            inited        <= inited_nx;
            pending       <= pending_nx;
            wdog          <= wdog_nx;
            start_init_tx <= start_init_nx;
            start_data_tx <= start_data_nx;
            gen_end_out   <= gen_end_nx;
            error         <= error_nx;
            core_dout     <= din;
            core_ctrl     <= core_ctrl_nx;
        end
    end

endmodule

// File: tb/tb_bcrypt_tx_arbiter.sv
// Directed bench for bcrypt_tx_arbiter: init order, round-robin dispatch,
// pending blocking, gen-end drain, watchdog timeout, spurious done and reset abort.
module tb_bcrypt_tx_arbiter;
    logic       CLK = 1'b0;
    logic       RST;
    logic       init_ready, data_ready, bcdata_gen_end;
    logic       start_init_tx, start_data_tx;
    logic       init_tx_done, data_tx_done;
    logic [7:0] din;
    logic [1:0] ctrl_in;
    logic [7:0] core_dout;
    logic [7:0] core_ctrl;
    logic [3:0] core_idle;
    logic       gen_end_out;
    logic [1:0] error;

    logic [3:0] idle_base;
    int         checks = 0;
    int         errors = 0;

    bcrypt_tx_arbiter #(.N_CORES(4), .TIMEOUT(64)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .init_ready     (init_ready),
        .data_ready     (data_ready),
        .bcdata_gen_end (bcdata_gen_end),
        .start_init_tx  (start_init_tx),
        .start_data_tx  (start_data_tx),
        .init_tx_done   (init_tx_done),
        .data_tx_done   (data_tx_done),
        .din            (din),
        .ctrl_in        (ctrl_in),
        .core_dout      (core_dout),
        .core_ctrl      (core_ctrl),
        .core_idle      (core_idle),
        .gen_end_out    (gen_end_out),
        .error          (error)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic wait_start(input bit is_data, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (is_data ? start_data_tx : start_init_tx) seen = 1'b1;
        end
    endtask

    task automatic do_init(input int e);
        bit         seen;
        logic [7:0] want;
        wait_start(1'b0, 10, seen);
        check("init_start", seen, 1);
        check("init_excl", start_data_tx, 0);
        ctrl_in = 2'b10;
        din     = 8'(8'h30 + e);
        @(negedge CLK);
        want = '0;
        want[2*e +: 2] = 2'b10;
        check("init_ctrl_lane", core_ctrl, want);
        check("init_dout", core_dout, 8'(8'h30 + e));
        ctrl_in = 2'b00;
        repeat (3) @(negedge CLK);
        check("init_no_restart", start_init_tx, 0);
        init_tx_done = 1'b1;
        @(negedge CLK);
        init_tx_done = 1'b0;
    endtask

    task automatic do_batch(input int e, input bit drop, input int done_at);
        bit         seen;
        logic [7:0] want;
        data_ready     = 1'b1;
        bcdata_gen_end = 1'b0;
        wait_start(1'b1, 12, seen);
        check("data_start", seen, 1);
        check("data_excl", start_init_tx, 0);
        data_ready = 1'b0;
        ctrl_in    = 2'b01;
        @(negedge CLK);
        want = '0;
        want[2*e +: 2] = 2'b01;
        check("data_ctrl_lane", core_ctrl, want);
        ctrl_in = 2'b00;
        @(negedge CLK);
        if (drop) core_idle = idle_base & ~(4'b0001 << e);
        @(negedge CLK);
        core_idle = idle_base;
        repeat (done_at - 3) @(negedge CLK);
        data_tx_done = 1'b1;
        @(negedge CLK);
        data_tx_done = 1'b0;
    endtask

    initial begin
        bit seen;
        RST            = 1'b1;
        init_ready     = 1'b0;
        data_ready     = 1'b0;
        bcdata_gen_end = 1'b0;
        init_tx_done   = 1'b0;
        data_tx_done   = 1'b0;
        din            = 8'hA5;
        ctrl_in        = 2'b11;
        idle_base      = 4'hF;
        core_idle      = 4'hF;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_start_init", start_init_tx, 0);
        check("rst_start_data", start_data_tx, 0);
        check("rst_gen_end", gen_end_out, 0);
        check("rst_error", error, 0);
        check("rst_core_ctrl", core_ctrl, 0);
        check("rst_core_dout", core_dout, 0);
        ctrl_in    = 2'b00;
        init_ready = 1'b1;
        RST        = 1'b0;

        // Init sweep in index order
        for (int e = 0; e < 4; e++) do_init(e);
        wait_start(1'b0, 10, seen);
        check("init_all_done", seen, 0);

        // Core 2 busy: skipped by round robin
        idle_base = 4'b1011;
        core_idle = idle_base;
        do_batch(0, 1'b1, 20);
        do_batch(1, 1'b1, 20);
        do_batch(3, 1'b1, 20);
        do_batch(0, 1'b1, 20);
        idle_base = 4'hF;
        core_idle = idle_base;

        // Cores acknowledge by dropping idle: plain rotation from rr=1
        do_batch(1, 1'b1, 20);
        do_batch(2, 1'b1, 20);
        do_batch(3, 1'b1, 20);
        do_batch(0, 1'b1, 20);
        do_batch(1, 1'b1, 20);
        do_batch(2, 1'b1, 20);

        // Cores never drop idle: pending blocks the fifth batch
        do_batch(3, 1'b0, 20);
        do_batch(0, 1'b0, 20);
        do_batch(1, 1'b0, 20);
        do_batch(2, 1'b0, 20);
        data_ready = 1'b1;
        wait_start(1'b1, 30, seen);
        check("blocked_by_pending", seen, 0);
        core_idle = 4'h0;
        @(negedge CLK);
        core_idle = idle_base;
        do_batch(3, 1'b1, 20);

        // Gen-end marker waits for core 1 to go idle
        idle_base      = 4'b1101;
        core_idle      = idle_base;
        data_ready     = 1'b1;
        bcdata_gen_end = 1'b1;
        wait_start(1'b1, 15, seen);
        check("gen_end_held", seen, 0);
        check("gen_end_early", gen_end_out, 0);
        idle_base = 4'hF;
        core_idle = idle_base;
        wait_start(1'b1, 5, seen);
        check("gen_end_start", seen, 1);
        data_ready     = 1'b0;
        bcdata_gen_end = 1'b0;
        ctrl_in        = 2'b11;
        @(negedge CLK);
        check("gen_end_no_ctrl", core_ctrl, 0);
        check("gen_end_no_pulse_yet", gen_end_out, 0);
        repeat (3) @(negedge CLK);
        data_tx_done = 1'b1;
        @(negedge CLK);
        data_tx_done = 1'b0;
        check("gen_end_pulse", gen_end_out, 1);
        @(negedge CLK);
        check("gen_end_single", gen_end_out, 0);
        check("gen_end_no_restart", start_data_tx, 0);
        check("gen_end_error", error, 0);
        ctrl_in = 2'b00;

        // Watchdog: no data_tx_done after start
        data_ready = 1'b1;
        wait_start(1'b1, 12, seen);
        check("wd_start", seen, 1);
        data_ready = 1'b0;
        repeat (63) @(negedge CLK);
        check("wd_before", error, 2'b00);
        @(negedge CLK);
        check("wd_expired", error, 2'b01);
        data_ready = 1'b1;
        ctrl_in    = 2'b01;
        wait_start(1'b1, 20, seen);
        check("wd_no_start", seen, 0);
        check("wd_no_init", start_init_tx, 0);
        check("wd_ctrl_forced", core_ctrl, 0);
        init_ready = 1'b0;
        data_ready = 1'b0;
        ctrl_in    = 2'b00;
        RST        = 1'b1;
        #1;
        check("wd_rst_clears", error, 2'b00);
        @(negedge CLK);
        RST = 1'b0;

        // Spurious data_tx_done in IDLE
        @(negedge CLK);
        data_tx_done = 1'b1;
        @(negedge CLK);
        data_tx_done = 1'b0;
        check("spurious_done", error, 2'b10);
        init_ready = 1'b1;
        wait_start(1'b0, 10, seen);
        check("spurious_no_start", seen, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("spurious_rst", error, 2'b00);
        RST = 1'b0;

        // Reset mid-init aborts and forgets initialised cores
        do_init(0);
        wait_start(1'b0, 10, seen);
        check("mid_init_start", seen, 1);
        ctrl_in = 2'b11;
        din     = 8'h5A;
        @(negedge CLK);
        check("mid_init_lane", core_ctrl, 8'b0000_1100);
        RST = 1'b1;
        #1;
        check("mid_rst_ctrl", core_ctrl, 0);
        check("mid_rst_dout", core_dout, 0);
        check("mid_rst_start", start_init_tx, 0);
        check("mid_rst_error", error, 0);
        @(negedge CLK);
        RST     = 1'b0;
        ctrl_in = 2'b00;
        do_init(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
